// File: rtl/conv3d_fold.sv
// conv3d_fold: one window convolved against CHANNELS_OUT filters, PAR_OUT lanes per pass,
// followed by round-half-up shift and ReLU/unsigned or signed saturation.
module conv3d_fold #(
  parameter int DIN_WIDTH    = 8,
  parameter int KERN_WIDTH   = 16,
  parameter int DOUT_WIDTH   = 8,
  parameter int WIN_SIZE     = 3,
  parameter int CHANNELS_IN  = 4,
  parameter int CHANNELS_OUT = 128,
  parameter int PAR_OUT      = 16,
  localparam int G     = CHANNELS_OUT / PAR_OUT,
  localparam int N     = WIN_SIZE * WIN_SIZE * CHANNELS_IN,
  localparam int ACC_W = DIN_WIDTH + KERN_WIDTH + $clog2(N) + 2,
  localparam int GW    = (G > 1) ? $clog2(G) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [CHANNELS_OUT-1:0][CHANNELS_IN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][KERN_WIDTH-1:0] kernel,
  input  logic [CHANNELS_OUT-1:0][ACC_W-1:0] bias,
  input  logic [4:0] shift,
  input  logic relu_en,
  input  logic win_vld,
  output logic win_rdy,
  input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][CHANNELS_IN-1:0][DIN_WIDTH-1:0] window,
  output logic dout_vld,
  input  logic dout_rdy,
  output logic [PAR_OUT-1:0][DOUT_WIDTH-1:0] dout,
  output logic [GW-1:0] dout_grp,
  output logic dout_last
);

  localparam int CW = (CHANNELS_OUT > 1) ? $clog2(CHANNELS_OUT) : 1;

  localparam logic signed [ACC_W:0] U_MAX = {{(ACC_W + 1 - DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};
  localparam logic signed [ACC_W:0] S_MAX = {{(ACC_W + 2 - DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] S_MIN = {{(ACC_W + 2 - DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;

  state_t state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][CHANNELS_IN-1:0][DIN_WIDTH-1:0] win_q, win_d;
  logic [4:0] shift_q, shift_d;
  logic relu_q, relu_d;
  logic [PAR_OUT-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [PAR_OUT-1:0][DOUT_WIDTH-1:0] dout_q, dout_d;
  logic dout_vld_q, dout_vld_d;
  logic [GW-1:0] dout_grp_q, dout_grp_d;
  logic dout_last_q, dout_last_d;

  logic [PAR_OUT-1:0][ACC_W-1:0] mac_sum;
  logic [PAR_OUT-1:0][DOUT_WIDTH-1:0] post_val;
  logic last_grp;

  assign last_grp = (grp_q == GW'(G - 1));

  for (genvar gp = 0; gp < PAR_OUT; gp++) begin : g_lane
    logic [CW-1:0] c_idx;
    logic [N-1:0][ACC_W-1:0] prods;
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W:0] ext, rnd, rsh;
    logic [DOUT_WIDTH-1:0] sat;

    // Only PAR_OUT multiplier lanes exist; the group index picks which filters feed them.
    assign c_idx = CW'(grp_q * PAR_OUT + gp);

    for (genvar gy = 0; gy < WIN_SIZE; gy++) begin : g_y
      for (genvar gx = 0; gx < WIN_SIZE; gx++) begin : g_x
        for (genvar gc = 0; gc < CHANNELS_IN; gc++) begin : g_c
          logic [KERN_WIDTH-1:0] k_raw;
          logic signed [ACC_W-1:0] w_e, k_e;
          assign k_raw = kernel[c_idx][gc][gy][gx];
          assign w_e = {{(ACC_W - DIN_WIDTH){1'b0}}, win_q[gy][gx][gc]};
          assign k_e = {{(ACC_W - KERN_WIDTH){k_raw[KERN_WIDTH-1]}}, k_raw};
          assign prods[(gy * WIN_SIZE + gx) * CHANNELS_IN + gc] = w_e * k_e;
        end
      end
    end

    always_comb begin
      lane_sum = $signed(bias[c_idx]);
      for (int i = 0; i < N; i++) begin
        lane_sum = lane_sum + $signed(prods[i]);
      end
    end

    assign mac_sum[gp] = lane_sum;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    always_comb begin
      ext = {acc_q[gp][ACC_W-1], acc_q[gp]};
      rnd = (shift_q == 5'd0) ? '0 : ((ACC_W + 1)'(1) << (shift_q - 5'd1));
      rsh = (ext + rnd) >>> shift_q;
      if (relu_q) begin
        if (rsh[ACC_W])
          sat = '0;
        else if (rsh > U_MAX)
          sat = '1;
        else
          sat = rsh[DOUT_WIDTH-1:0];
      end else begin
        if (rsh > S_MAX)
          sat = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
        else if (rsh < S_MIN)
          sat = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};
        else
          sat = rsh[DOUT_WIDTH-1:0];
      end
    end

    assign post_val[gp] = sat;
  end

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    win_d       = win_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    dout_vld_d  = dout_vld_q;
    dout_grp_d  = dout_grp_q;
    dout_last_d = dout_last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          win_d   = window;
          shift_d = shift;
          relu_d  = relu_en;
          grp_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d   = mac_sum;
        state_d = POST;
      end
      POST: begin
        dout_d      = post_val;
        dout_grp_d  = grp_q;
        dout_last_d = last_grp;
        dout_vld_d  = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          if (last_grp) begin
            state_d = IDLE;
          end else begin
            grp_d   = grp_q + GW'(1);
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      win_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_grp_q  <= '0;
      dout_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      win_q       <= win_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_grp_q  <= dout_grp_d;
      dout_last_q <= dout_last_d;
    end
  end

  // Gated by reset so the block never advertises readiness while held in reset.
  assign win_rdy   = (state_q == IDLE) && !reset;
  assign dout_vld  = dout_vld_q;
  assign dout      = dout_q;
  assign dout_grp  = dout_grp_q;
  assign dout_last = dout_last_q;

endmodule

// File: doc/conv3d_fold.md
CONV3D_FOLD -- requirements
Module: conv3d_fold

Interface
REQ-001 SHALL have parameters: DIN_WIDTH, default 8, unsigned window sample width; KERN_WIDTH, default 16, signed weight width; DOUT_WIDTH, default 8, output sample width; WIN_SIZE, default 3, square window side; CHANNELS_IN, default 4, input depth; CHANNELS_OUT, default 128, output channels; PAR_OUT, default 16, channels computed per group, must divide CHANNELS_OUT.
REQ-002 SHALL derive G = CHANNELS_OUT/PAR_OUT, N = WIN_SIZE*WIN_SIZE*CHANNELS_IN, ACC_W = DIN_WIDTH+KERN_WIDTH+clog2(N)+2.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 kernel  in  [CHANNELS_OUT][CHANNELS_IN][WIN_SIZE][WIN_SIZE][KERN_WIDTH]  static weights.
REQ-006 bias  in  [CHANNELS_OUT][ACC_W]  signed per-channel bias, static.
REQ-007 shift  in  5  right-shift amount, 0..ACC_W-1; relu_en  in  1  ReLU mode; both sampled at window acceptance.
REQ-008 win_vld  in  1; win_rdy  out  1; window  in  [WIN_SIZE][WIN_SIZE][CHANNELS_IN][DIN_WIDTH].
REQ-009 dout_vld  out  1; dout_rdy  in  1; dout  out  [PAR_OUT][DOUT_WIDTH]; dout_grp  out  clog2(G) (min 1); dout_last  out  1.

Function
REQ-010 SHALL use FSM states IDLE, MAC, POST, OUT.
REQ-011 IDLE: win_rdy=1; on win_vld=1 capture window, shift, relu_en; grp<=0; go MAC. win_rdy SHALL be 0 in all other states.
REQ-012 MAC (1 cycle): for p in 0..PAR_OUT-1, c=grp*PAR_OUT+p, register acc[p] = bias[c] + sum over N of window(unsigned, zero-extended) * kernel[c](signed); go POST.
REQ-013 POST (1 cycle): register dout[p] from acc[p] per REQ-016..018, dout_grp<=grp, dout_last<=(grp==G-1), dout_vld<=1; go OUT.
REQ-014 OUT: hold dout, dout_grp, dout_last, dout_vld stable until dout_rdy=1; on handshake dout_vld<=0; if grp==G-1 go IDLE else grp<=grp+1, go MAC.
REQ-015 Latency: dout_vld rises 2 cycles after the window-accept edge and 2 cycles after each non-last output handshake; minimum 3 cycles per group, 3*G+1 cycles per window with dout_rdy tied high.
REQ-016 Rounding: if shift>0, r = (acc + 2^(shift-1)) >>> shift (arithmetic); else r = acc; no intermediate overflow (ACC_W wide).
REQ-017 relu_en=1: r<0 -> 0; r>2^DOUT_WIDTH-1 -> 2^DOUT_WIDTH-1; output unsigned.
REQ-018 relu_en=0: saturate r to signed range [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; output two's complement.
REQ-019 win_vld while win_rdy=0 SHALL be ignored; the captured window is not altered until return to IDLE.
REQ-020 Changes of kernel or bias during a window SHALL be sampled in MAC as-is; upstream keeps them static per frame.
REQ-021 When G==1, dout_grp=0 and dout_last=1 on every output.

Reset
REQ-022 reset=1 SHALL immediately force state IDLE, grp=0, dout_vld=0, dout=0, dout_grp=0, dout_last=0, captured shift/relu_en=0.
REQ-023 win_rdy SHALL be 0 while reset=1 and 1 in the first cycle after release.
REQ-024 Reset during MAC, POST or OUT SHALL discard the window in progress; the next accepted window restarts at group 0.

Verification (WIN_SIZE=3, CHANNELS_IN=1, CHANNELS_OUT=4, PAR_OUT=2, DIN=8, KERN=8, DOUT=8)
REQ-025 All window=1, kernel[c] all weights c+1, bias 0, shift 0, relu 0, dout_rdy=1 -> grp0 dout {9,18}, grp1 {27,36}; dout_vld 2 cycles after accept; dout_last=1 only on grp1; win_rdy=1 the cycle after grp1 handshake.
REQ-026 Window=255, weights 127 -> dout 127 (relu 0); weights -128 -> -128 (relu 0), 0 (relu 1); window=255, weights 127, relu 1 -> 255.
REQ-027 Rounding, shift=2: acc 6 -> 2; acc 5 -> 1; acc -6 -> -1; bias -9 with acc contribution 9 -> 0.
REQ-028 dout_rdy=0 for 5 cycles on grp0 -> dout, dout_grp, dout_last stable, dout_vld=1, win_rdy=0, pulsing win_vld has no effect; release -> grp1 valid 2 cycles later.
REQ-029 reset pulse during OUT of grp1 -> dout_vld=0 asynchronously; after release win_rdy=1; next window yields grp0 first with correct values.
REQ-030 win_vld held high, two windows, dout_rdy=1 -> second window accepted exactly 1 cycle after first window's last handshake; outputs grp0,grp1,grp0,grp1 with no loss.
